rom_burst_reader: RTL and testbench

- Parametrised successor to the single-port latched-address ROM model used by the OMP processor sim, with two read paths into one shared memory array.
- Random-access port: the legacy latched-address, OE-gated, tri-state read.
- Burst port: a start/length command streams consecutive words, LANES per beat, over a valid/ready handshake with wrap-around addressing.
- Feeds the measurement/dictionary datapaths, which consume Y/A samples as streams.

---
 rtl/rom_burst_reader.sv | 154 +++++++++++++++
 tb/tb_rom_burst_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Shared-array ROM with a latched-address random-access port and a
// start/length burst streamer (LANES words per beat, wrap-around addressing).
module rom_burst_reader #(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 10,
  parameter int    MEM_SIZE   = 1024,
  parameter int    LANES      = 1,
  parameter int    LEN_WIDTH  = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                          CK,
  input  logic                          RST,
  input  logic [ADDR_WIDTH-1:0]         A,
  input  logic                          OE,
  output logic [DATA_WIDTH-1:0]         Q,
  input  logic                          START,
  input  logic [ADDR_WIDTH-1:0]         START_A,
  input  logic [LEN_WIDTH-1:0]          LEN,
  input  logic                          ABORT,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [LANES*DATA_WIDTH-1:0]   OUT_DATA,
  output logic                          OUT_LAST,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  state_t                        state_q;
  state_t                        state_d;
  logic [ADDR_WIDTH-1:0]         a_q;
  logic [ADDR_WIDTH-1:0]         beat_addr;
  logic [ADDR_WIDTH-1:0]         next_addr;
  logic [ADDR_WIDTH-1:0]         lane_a;
  logic [LEN_WIDTH-1:0]          beats_left;
  logic [LANES*DATA_WIDTH-1:0]   fetch_data;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic                          done_q;
  logic                          err_q;
  logic                          start_ok;
  logic                          xfer;
  logic                          last;
  logic                          cap;
  logic                          load;
  logic                          dec;
  logic                          done_d;
  logic                          err_d;

  function automatic logic [ADDR_WIDTH-1:0] inc(
    input logic [ADDR_WIDTH-1:0] x
  );
    return (32'(x) == MEM_SIZE - 1) ? '0 : x + ADDR_WIDTH'(1);
  endfunction

  always_ff @(posedge CK) begin
    if (RST) a_q <= '0;
    else     a_q <= A;
  end

  assign Q = !OE ? {DATA_WIDTH{1'bz}} :
             (32'(a_q) >= MEM_SIZE) ? {DATA_WIDTH{1'bx}} :
             mem[a_q];

  // Walk LANES consecutive words; the address after the last lane
  // is where the following beat begins.
  always_comb begin
    fetch_data = '0;
    lane_a     = beat_addr;
    for (int k = 0; k < LANES; k++) begin
      fetch_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[lane_a];
      lane_a = inc(lane_a);
    end
    next_addr = lane_a;
  end

  assign start_ok = START && (LEN != '0) && (32'(START_A) < MEM_SIZE);
  assign xfer     = OUT_VALID && OUT_READY;
  assign last     = (beats_left == LEN_WIDTH'(1));

  always_ff @(posedge CK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_ok) state_d = FETCH;
      FETCH:  state_d = ABORT ? IDLE : STREAM;
      STREAM: begin
        if (ABORT)             state_d = IDLE;
        else if (xfer && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap    = 1'b0;
    load   = 1'b0;
    dec    = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cap   = start_ok;
        err_d = START && !start_ok;
      end
      FETCH:  load = 1'b1;
      STREAM: begin
        if (xfer && !ABORT) begin
          dec    = 1'b1;
          load   = !last;
          done_d = last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      beat_addr  <= '0;
      beats_left <= '0;
      out_data   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (cap) begin
        beat_addr  <= START_A;
        beats_left <= LEN;
      end
      if (load) begin
        out_data  <= fetch_data;
        beat_addr <= next_addr;
      end
      if (dec) beats_left <= beats_left - LEN_WIDTH'(1);
    end
  end

  assign OUT_VALID = (state_q == STREAM);
  assign OUT_LAST  = OUT_VALID && last;
  assign OUT_DATA  = out_data;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: a 1-lane and a 2-lane instance
// (both 1000 words) run the same commands against a beat scoreboard.
module tb_rom_burst_reader;

  logic        clk;
  logic        rst;
  logic [9:0]  a;
  logic        oe;
  logic        start;
  logic [9:0]  start_a;
  logic [7:0]  len;
  logic        abort;
  logic        rdy;

  wire  [15:0] q1;
  wire  [15:0] q2;
  logic        v1, l1, b1, dn1, e1;
  logic        v2, l2, b2, dn2, e2;
  logic [15:0] d1;
  logic [31:0] d2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] sb1 [$];
  logic [32:0] sb2 [$];
  logic        hold1 = 1'b0;
  logic        hold2 = 1'b0;
  logic [32:0] held1 = '0;
  logic [32:0] held2 = '0;

  rom_burst_reader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_SIZE(1000),
    .LANES(1), .LEN_WIDTH(8), .INIT_FILE("")
  ) u1 (
    .CK(clk), .RST(rst), .A(a), .OE(oe), .Q(q1),
    .START(start), .START_A(start_a), .LEN(len), .ABORT(abort),
    .OUT_VALID(v1), .OUT_READY(rdy), .OUT_DATA(d1), .OUT_LAST(l1),
    .BUSY(b1), .DONE(dn1), .ERR(e1)
  );

  rom_burst_reader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_SIZE(1000),
    .LANES(2), .LEN_WIDTH(8), .INIT_FILE("")
  ) u2 (
    .CK(clk), .RST(rst), .A(a), .OE(oe), .Q(q2),
    .START(start), .START_A(start_a), .LEN(len), .ABORT(abort),
    .OUT_VALID(v2), .OUT_READY(rdy), .OUT_DATA(d2), .OUT_LAST(l2),
    .BUSY(b2), .DONE(dn2), .ERR(e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word(int x);
    return 16'((x % 1000) + 256);
  endfunction

  function automatic logic [4:0] st1();
    return {v1, l1, b1, dn1, e1};
  endfunction

  function automatic logic [4:0] st2();
    return {v2, l2, b2, dn2, e2};
  endfunction

  task automatic push_burst(int sa, int n);
    for (int b = 0; b < n; b++) begin
      sb1.push_back({b == n - 1, 16'h0, word(sa + b)});
      sb2.push_back({b == n - 1, word(sa + 2*b + 1), word(sa + 2*b)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(int sa, int n, bit ok);
    start   = 1'b1;
    start_a = 10'(sa);
    len     = 8'(n);
    if (ok) push_burst(sa, n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (b1 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", {63'h0, b1}, 64'h0);
  endtask

  // Transfers happen at the coming posedge; sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && !abort && rdy && v1) begin
      if (sb1.size() == 0) chk("extra_beat1", 64'h1, 64'h0);
      else chk("beat1", {l1, 16'h0, d1}, sb1.pop_front());
    end
    if (hold1 && v1) chk("hold1", {l1, 16'h0, d1}, held1);
    hold1 <= v1 && !rdy && !rst && !abort;
    held1 <= {l1, 16'h0, d1};
  end

  always @(negedge clk) begin
    if (!rst && !abort && rdy && v2) begin
      if (sb2.size() == 0) chk("extra_beat2", 64'h1, 64'h0);
      else chk("beat2", {l2, d2}, sb2.pop_front());
    end
    if (hold2 && v2) chk("hold2", {l2, d2}, held2);
    hold2 <= v2 && !rdy && !rst && !abort;
    held2 <= {l2, d2};
  end

  initial begin
    logic [5:0] pat;
    pat = 6'b101001;
    rst = 1'b1; a = 10'd5; oe = 1'b1;
    start = 1'b0; start_a = '0; len = '0;
    abort = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      u1.mem[i] = 16'(i + 256);
      u2.mem[i] = 16'(i + 256);
    end
    tick();
    tick();

    chk("rst_stat1", {59'h0, st1()}, 64'h0);
    chk("rst_stat2", {59'h0, st2()}, 64'h0);
    chk("rst_data1", {48'h0, d1}, 64'h0);
    chk("rst_data2", {32'h0, d2}, 64'h0);
    chk("rst_alatch", {48'h0, q1}, 64'h100);

    rst = 1'b0;
    tick();
    chk("ra_q1", {48'h0, q1}, 64'h105);
    chk("ra_q2", {48'h0, q2}, 64'h105);
    oe = 1'b0;
    #1;
    chk("ra_oe0", {63'h0, q1 === 16'h0105}, 64'h0);
    oe = 1'b1; a = 10'd7;
    #1;
    chk("ra_noedge", {48'h0, q1}, 64'h105);
    tick();
    chk("ra_next", {48'h0, q1}, 64'h107);

    cmd(10, 4, 1);
    chk("lat_t1", {59'h0, st1()}, 64'b00100);
    tick();
    chk("lat_t2", {63'h0, v1}, 64'h1);
    chk("lat_t2b", {63'h0, v2}, 64'h1);
    repeat (4) tick();
    chk("done1", {59'h0, st1()}, 64'b00010);
    chk("done2", {59'h0, st2()}, 64'b00010);
    tick();
    chk("done_pulse", {63'h0, dn1}, 64'h0);

    cmd(998, 3, 1);
    wait_idle(20);

    cmd(100, 3, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      rdy = pat[i];
      tick();
    end
    chk("bp_done1", {59'h0, st1()}, 64'b00010);
    chk("bp_done2", {59'h0, st2()}, 64'b00010);
    rdy = 1'b1;

    cmd(5, 0, 0);
    chk("err_len0", {59'h0, st1()}, 64'b00001);
    tick();
    chk("err_pulse", {63'h0, e1}, 64'h0);
    cmd(1000, 2, 0);
    chk("err_addr1", {59'h0, st1()}, 64'b00001);
    chk("err_addr2", {59'h0, st2()}, 64'b00001);

    cmd(200, 4, 1);
    tick();
    cmd(300, 2, 0);
    chk("busy_ign", {62'h0, e1, b1}, 64'b01);
    wait_idle(20);
    tick();
    chk("busy_after", {63'h0, b1}, 64'h0);
    chk("busy_sb", 64'(sb1.size() + sb2.size()), 64'h0);

    cmd(50, 5, 1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_st1", {59'h0, st1()}, 64'h0);
    chk("abort_st2", {59'h0, st2()}, 64'h0);
    chk("abort_left", 64'(sb1.size()), 64'd3);
    chk("abort_left2", 64'(sb2.size()), 64'd3);
    sb1.delete();
    sb2.delete();
    tick();
    chk("abort_nodone", {63'h0, dn1}, 64'h0);
    abort = 1'b1;
    cmd(60, 2, 1);
    abort = 1'b0;
    chk("abort_start", {63'h0, b1}, 64'h1);
    wait_idle(20);

    cmd(400, 5, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_st1", {59'h0, st1()}, 64'h0);
    chk("mrst_st2", {59'h0, st2()}, 64'h0);
    chk("mrst_d", {16'h0, d2, d1}, 64'h0);
    chk("mrst_left", 64'(sb1.size()), 64'd4);
    sb1.delete();
    sb2.delete();
    a = 10'd5;
    tick();
    chk("mrst_mem", {48'h0, q1}, 64'h105);
    cmd(5, 1, 1);
    wait_idle(20);
    tick();

    chk("sb1_empty", 64'(sb1.size()), 64'h0);
    chk("sb2_empty", 64'(sb2.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
